bpsk_mapper: RTL and testbench
==============================

// Module: bpsk_mapper
// PURPOSE
//  Downstream consumer of the carrier-phase counter (counter, NUM samples/carrier cycle).
//  Accepts a serial bit stream over a valid/ready handshake and emits one BPSK symbol per
//  counter period: bit 0 -> +sin carrier, bit 1 -> -sin carrier (pi phase flip).
//  Symbols always start at counter_sig==0. On underrun the output is driven to zero.
//  Output feeds the DAC/filter stage.
// PARAMETERS
//  NUM    16  samples per carrier cycle = samples per symbol; must match counter NUM, >=4
//  WIDTH   8  signed output sample width; amplitude A = 2^(WIDTH-1)-1
// PORTS
//  clk_sig       in   1             system clock, all logic on rising edge
//  reset_sig     in   1             synchronous reset, active-high
//  counter_sig   in   $clog2(NUM)   phase index from counter, counts 0..NUM-1 and wraps
//  bit_valid     in   1             upstream bit present
//  bit_data      in   1             bit value
//  bit_ready     out  1             mapper can accept a bit this cycle
//  sample_sig    out  WIDTH signed  carrier sample
//  sample_valid  out  1             sample_sig belongs to an active symbol
//  sym_start     out  1             pulse with the index-0 sample of each symbol
// BEHAVIOUR
//  - ROM lut[k] = round(A*sin(2*pi*k/NUM)), k=0..NUM-1, built at elaboration (real math).
//  - Registers: state {IDLE,RUN}, cur_bit, pend_full, pend_bit, sample_sig,
//    sample_valid, sym_start.
//  - Reset (edge with reset_sig=1): state=IDLE, pend_full=0, cur_bit=0, sample_sig=0,
//    sample_valid=0, sym_start=0. bit_ready=0 while reset_sig=1.
//    Mid-symbol reset discards the current and pending bits.
//  - bit_ready = !pend_full && !reset_sig (combinational). Handshake = bit_valid && bit_ready.
//  - Handshake with no boundary: pend_bit<=bit_data, pend_full<=1.
//  - Boundary = edge sampling counter_sig==NUM-1. The next symbol is chosen at the boundary:
//      pend_full=1            : cur_bit<=pend_bit, pend_full<=0, state<=RUN
//      pend_full=0, handshake : bypass: cur_bit<=bit_data, pend stays empty, state<=RUN
//      pend_full=0, no hs     : state<=IDLE
//  - The state only changes at a boundary. IDLE->RUN is therefore only possible at a wrap,
//    which guarantees phase alignment.
//  - Output path, every edge sampling index k, using the pre-edge state/cur_bit:
//      RUN : sample_sig<=cur_bit ? -lut[k] : lut[k]; sample_valid<=1; sym_start<=(k==0)
//      IDLE: sample_sig<=0; sample_valid<=0; sym_start<=0
//    Latency: one cycle from counter_sig to sample_sig.
//    The sample at index NUM-1 belongs to the old symbol. The new symbol starts with the
//    sample for index 0, one cycle after counter_sig shows 0.
//  - Back-to-back symbols have no gap as long as a bit is pending or offered at each boundary.
//    At most one bit is buffered.
//  - Negation is safe because |lut[k]| <= A (no -2^(WIDTH-1) overflow).
//    Sample values are width-exact; there is no saturation logic.
// TESTING (NUM=16, WIDTH=8, A=127; counter free-running)
//  1. Reset for 2 cycles, release
//     -> bit_ready=1, sample_sig=0, sample_valid=0 until the first bit starts.
//  2. One bit 0 offered at counter=5
//     -> accepted (pend_full=1, ready=0).
//     -> Next symbol: k=0 sample 0 with sym_start=1; k=4 -> +127; k=8 -> 0; k=12 -> -127.
//     -> sample_valid=1 for exactly 16 cycles.
//  3. One bit 1 -> k=4 sample -127, k=12 sample +127.
//  4. Bits 0,1,0 held valid continuously
//     -> three contiguous 16-sample symbols, sym_start every 16 cycles.
//     -> Polarity +,-,+ at k=4; ready deasserts while pend_full=1.
//  5. Bit offered exactly when counter=15 with the pending buffer empty
//     -> bypass: symbol starts at the next k=0.
//     Last symbol with no follow-up bit -> sample_valid=0, sample_sig=0 after its k=15 sample.
//  6. reset_sig pulsed at k=7 of a symbol with a pending bit
//     -> next edge: outputs 0, pending bit lost.
//     -> The mapper restarts cleanly on a later offer.

Source files
------------

// File: rtl/bpsk_mapper.sv
// BPSK mapper: one +/-sin carrier symbol per counter period,
// bits taken over a valid/ready handshake with a one-deep buffer.
module bpsk_mapper #(
  parameter int NUM   = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_sig,
  input  logic                     reset_sig,
  input  logic [$clog2(NUM)-1:0]   counter_sig,
  input  logic                     bit_valid,
  input  logic                     bit_data,
  output logic                     bit_ready,
  output logic signed [WIDTH-1:0]  sample_sig,
  output logic                     sample_valid,
  output logic                     sym_start
);

  localparam int CW  = $clog2(NUM);
  localparam int AMP = 2**(WIDTH-1) - 1;

  function automatic logic signed [WIDTH-1:0] lut_val(input int k);
    real r;
    int  v;
    r = real'(AMP) *
        $sin(2.0 * 3.14159265358979 * real'(k) / real'(NUM));
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(0.5 - r);
    lut_val = v[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] lut [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_lut
    localparam logic signed [WIDTH-1:0] LV = lut_val(g);
    assign lut[g] = LV;
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic                    cur_bit_q, cur_bit_d;
  logic                    pend_full_q, pend_full_d;
  logic                    pend_bit_q, pend_bit_d;
  logic signed [WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    start_q, start_d;

  logic boundary;
  logic hs;

  assign bit_ready = !pend_full_q && !reset_sig;
  assign hs        = bit_valid && bit_ready;
  assign boundary  = counter_sig == CW'(NUM - 1);

  // Symbol selection only at the wrap keeps every symbol phase-aligned
  always_comb begin
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    pend_full_d = pend_full_q;
    pend_bit_d  = pend_bit_q;
    unique case (1'b1)
      boundary && pend_full_q: begin
        cur_bit_d   = pend_bit_q;
        pend_full_d = 1'b0;
        state_d     = RUN;
      end
      boundary && hs: begin
        cur_bit_d = bit_data;
        state_d   = RUN;
      end
      boundary && !pend_full_q && !hs: begin
        state_d = IDLE;
      end
      !boundary && hs: begin
        pend_bit_d  = bit_data;
        pend_full_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sample_d = '0;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    if (state_q == RUN) begin
      sample_d = cur_bit_q ? -lut[counter_sig] : lut[counter_sig];
      valid_d  = 1'b1;
      start_d  = counter_sig == '0;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q     <= IDLE;
      cur_bit_q   <= 1'b0;
      pend_full_q <= 1'b0;
      pend_bit_q  <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bit_q   <= cur_bit_d;
      pend_full_q <= pend_full_d;
      pend_bit_q  <= pend_bit_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
    end
  end

  assign sample_sig   = sample_q;
  assign sample_valid = valid_q;
  assign sym_start    = start_q;

endmodule

// File: tb/tb_bpsk_mapper.sv
// Scoreboard bench for bpsk_mapper: accepted bits queue their
// expected 16-sample symbol; a negedge monitor pops and compares.
module tb_bpsk_mapper;

  logic              clk = 1'b0;
  logic              reset_sig = 1'b1;
  logic [3:0]        cnt = 4'd0;
  logic              bit_valid = 1'b0;
  logic              bit_data = 1'b0;
  logic              bit_ready;
  logic signed [7:0] sample_sig;
  logic              sample_valid;
  logic              sym_start;

  typedef struct {
    int s;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   tbl[16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                    0, -49, -90, -117, -127, -117, -90, -49};

  bpsk_mapper #(.NUM(16), .WIDTH(8)) dut (
    .clk_sig     (clk),
    .reset_sig   (reset_sig),
    .counter_sig (cnt),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .sample_sig  (sample_sig),
    .sample_valid(sample_valid),
    .sym_start   (sym_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 4'd1;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic push_sym(input bit b);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.s  = b ? -tbl[k] : tbl[k];
      e.st = (k == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected sample", int'(sample_sig), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample", int'(sample_sig), e.s);
        check("sym_start", int'(sym_start), e.st);
      end
    end
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (int'(cnt) == v) return;
    end
    check("wait_cnt timeout", 0, 1);
  endtask

  task automatic offer(input bit b);
    bit_valid = 1'b1;
    bit_data  = b;
    for (int i = 0; i < 64; i++) begin
      if (bit_ready) begin
        push_sym(b);
        return;
      end
      @(negedge clk);
    end
    check("offer timeout", 0, 1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check({nm, " drained"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check({nm, " idle valid"}, int'(sample_valid), 0);
    check({nm, " idle sample"}, int'(sample_sig), 0);
    check({nm, " idle sym_start"}, int'(sym_start), 0);
  endtask

  initial begin
    int vcnt;
    // reset and idle
    repeat (2) @(negedge clk);
    check("ready in reset", int'(bit_ready), 0);
    reset_sig = 1'b0;
    #1;
    check("ready after reset", int'(bit_ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset idle valid", int'(sample_valid), 0);
      check("reset idle sample", int'(sample_sig), 0);
    end

    // single bit 0 buffered at counter 5
    wait_cnt(5);
    offer(1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    check("ready while pending", int'(bit_ready), 0);
    drain("bit0");

    // single bit 1
    wait_cnt(10);
    offer(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    drain("bit1");

    // back-to-back 0,1,0
    wait_cnt(2);
    offer(1'b0);
    @(negedge clk);
    offer(1'b1);
    @(negedge clk);
    offer(1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    drain("b2b");

    // bypass at counter 15
    wait_cnt(15);
    offer(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    check("bypass ready", int'(bit_ready), 1);
    drain("bypass");

    // reset mid-symbol with a pending bit
    wait_cnt(3);
    offer(1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    wait_cnt(1);
    offer(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    check("pend before reset", int'(bit_ready), 0);
    wait_cnt(7);
    reset_sig = 1'b1;
    #1;
    check("ready during pulse", int'(bit_ready), 0);
    @(negedge clk);
    check("rst valid", int'(sample_valid), 0);
    check("rst sample", int'(sample_sig), 0);
    check("rst sym_start", int'(sym_start), 0);
    exp_q.delete();
    reset_sig = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) vcnt++;
    end
    check("pending lost", vcnt, 0);
    check("ready after pulse", int'(bit_ready), 1);

    // clean restart
    wait_cnt(9);
    offer(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    drain("restart");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
